// File: rtl/uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the UART transmit path: the FSM state encoding, the
// default bit period in clock cycles and the 8N1 frame length.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        TXING = 1'b1
    } state_t;

    // Clock cycles per bit period (e.g. 100 MHz / 115200 baud ~ 868).
    localparam int BAUD_DIV_DEF = 868;

    // Start bit + 8 data bits + stop bit.
    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_if.sv
// ---------------------------------------------------------------------------
// uart_tx_if
// Handshake bundle between a byte producer and the UART transmitter.
//   trmt     : one-cycle request to start a frame
//   tx_data  : byte to send, sampled when trmt is accepted
//   clr_done : clears the sticky done flag
//   tx_done  : sticky frame-complete flag (from transmitter)
//   tx_busy  : frame on the line (from transmitter)
// master = producer side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface uart_tx_if;
    logic       trmt;
    logic [7:0] tx_data;
    logic       clr_done;
    logic       tx_done;
    logic       tx_busy;

    modport master (
        output trmt,
        output tx_data,
        output clr_done,
        input  tx_done,
        input  tx_busy
    );

    modport slave (
        input  trmt,
        input  tx_data,
        input  clr_done,
        output tx_done,
        output tx_busy
    );
endinterface

// File: rtl/uart_baud_cnt.sv
// ---------------------------------------------------------------------------
// uart_baud_cnt
// Bit-period counter shared by the UART transmitter and receiver. Counts
// 0..BAUD_DIV-1 while enabled and wraps to 0, pulsing tick in the last cycle
// of each bit period.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   clr  : synchronous clear to 0 (takes priority over en)
//   en   : count enable
//   tick : high in the final cycle of a bit period (cnt == BAUD_DIV-1 && en)
// ---------------------------------------------------------------------------
module uart_baud_cnt #(
    parameter int BAUD_DIV = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [9:0] LAST = 10'(BAUD_DIV - 1);

    logic [9:0] cnt_q;
    logic [9:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? 10'd0 : cnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// 8N1 UART transmitter. A trmt pulse in IDLE loads {stop, data, start} into a
// 10-bit shift register whose LSB drives TX, so the line is registered and
// falls one cycle after trmt. Each bit is held for BAUD_DIV cycles.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset (TX forced high at once)
//   bus : uart_tx_if.slave (trmt, tx_data, clr_done in; tx_done, tx_busy out)
//   TX  : serial output, idle high
// ---------------------------------------------------------------------------
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus,
    output logic      TX
);

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    state_t     state_q,   state_d;
    logic [9:0] shift_q,   shift_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       tx_done_q, tx_done_d;
    logic       baud_clr;
    logic       baud_tick;

    uart_baud_cnt #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (baud_clr),
        .en   (state_q == TXING),
        .tick (baud_tick)
    );

    assign TX          = shift_q[0];
    assign bus.tx_done = tx_done_q;
    assign bus.tx_busy = (state_q == TXING);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_done_d = tx_done_q;
        baud_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                // A new request outranks clr_done; both end with tx_done low.
                if (bus.trmt) begin
                    state_d   = TXING;
                    shift_d   = {1'b1, bus.tx_data, 1'b0};
                    bit_cnt_d = '0;
                    baud_clr  = 1'b1;
                    tx_done_d = 1'b0;
                end else if (bus.clr_done) begin
                    tx_done_d = 1'b0;
                end
            end
            TXING: begin
                if (bus.clr_done) begin
                    tx_done_d = 1'b0;
                end
                if (baud_tick) begin
                    // Shifting in ones leaves TX high once the stop bit ends.
                    shift_d   = {1'b1, shift_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    // Completion is assigned last so it wins over clr_done.
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = IDLE;
                        tx_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '1;
            bit_cnt_q <= '0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_done_q <= tx_done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic tx_a;
    logic tx4;

    uart_tx_if bus868 ();
    uart_tx_if bus4 ();

    uart_tx #(.BAUD_DIV(868)) dut868 (
        .clk (clk),
        .rst (rst_a),
        .bus (bus868),
        .TX  (tx_a)
    );

    uart_tx #(.BAUD_DIV(4)) dut4 (
        .clk (clk),
        .rst (rst_b),
        .bus (bus4),
        .TX  (tx4)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] exp_bits;   // bit i = line level during bit period i
        int         exp_dur;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Starts a frame on dut4 and follows it to tx_done. inj_kind 1 pulses
    // trmt (data 0x55) at window inj_at, inj_kind 2 pulses clr_done there.
    task automatic run4(input logic [7:0] d, input logic clr0, input int inj_kind,
                        input int inj_at, output logic [9:0] bits, output int dur,
                        output logic [2:0] first, output logic [63:0] trace);
        bus4.tx_data  = d;
        bus4.trmt     = 1'b1;
        bus4.clr_done = clr0;
        tick();
        bits  = '1;
        dur   = -1;
        trace = '1;
        first = {bus4.tx_done, bus4.tx_busy, tx4};
        for (int n = 0; n <= 60; n++) begin
            bus4.trmt     = (inj_kind == 1 && n == inj_at);
            bus4.clr_done = (inj_kind == 2 && n == inj_at);
            if (inj_kind == 1 && n == inj_at) bus4.tx_data = 8'h55;
            trace[n] = tx4;
            if (n % 4 == 2 && n < 40) bits[n / 4] = tx4;
            if (bus4.tx_done) begin
                dur = n;
                break;
            end
            tick();
        end
        bus4.trmt     = 1'b0;
        bus4.clr_done = 1'b0;
    endtask

    initial begin
        logic [9:0]  bits;
        logic [2:0]  first;
        logic [63:0] trace;
        int          dur;

        vecs[0] = '{8'h3C, 10'b1001111000, 40};
        vecs[1] = '{8'hFF, 10'b1111111110, 40};
        vecs[2] = '{8'h00, 10'b1000000000, 40};
        vecs[3] = '{8'h01, 10'b1000000010, 40};
        vecs[4] = '{8'hA5, 10'b1101001010, 40};

        bus868.trmt = 1'b0; bus868.tx_data = 8'h00; bus868.clr_done = 1'b0;
        bus4.trmt   = 1'b0; bus4.tx_data   = 8'h00; bus4.clr_done   = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_tx868",   {63'd0, tx_a}, 64'd1);
        check("rst_done868", {63'd0, bus868.tx_done}, 64'd0);
        check("rst_busy4",   {63'd0, bus4.tx_busy}, 64'd0);
        check("rst_tx4",     {63'd0, tx4}, 64'd1);
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();

        // 0xA5 at BAUD_DIV=868, mid-bit samples and frame length
        bus868.tx_data = 8'hA5;
        bus868.trmt    = 1'b1;
        tick();
        bus868.trmt = 1'b0;
        check("a5_868_latency", {63'd0, tx_a}, 64'd0);
        bits = '1;
        dur  = -1;
        for (int n = 0; n <= 9000; n++) begin
            if (n % 868 == 434 && n < 8680) bits[n / 868] = tx_a;
            if (bus868.tx_done) begin
                dur = n;
                break;
            end
            tick();
        end
        check("a5_868_bits", 64'(bits), 64'(10'b1101001010));
        check("a5_868_dur",  64'(dur), 64'd8680);
        check("a5_868_idle_tx", {63'd0, tx_a}, 64'd1);

        // Table of frames at BAUD_DIV=4, issued back-to-back
        for (int i = 0; i < 5; i++) begin
            run4(vecs[i].data, 1'b0, 0, -1, bits, dur, first, trace);
            check($sformatf("tbl%0d_first", i), 64'(first), 64'(3'b010));
            check($sformatf("tbl%0d_bits", i),  64'(bits),  64'(vecs[i].exp_bits));
            check($sformatf("tbl%0d_dur", i),   64'(dur),   64'(vecs[i].exp_dur));
        end

        // tx_done is sticky in IDLE, line stays high
        repeat (6) tick();
        check("sticky_done", {63'd0, bus4.tx_done}, 64'd1);
        check("sticky_tx",   {63'd0, tx4}, 64'd1);

        // 0x01 at BAUD_DIV=4: low cycles 0-3, high cycles 4-7, 40 cycles total
        run4(8'h01, 1'b0, 0, -1, bits, dur, first, trace);
        check("x01_start_low", 64'(trace[3:0]), 64'h0);
        check("x01_d0_high",   64'(trace[7:4]), 64'hF);
        check("x01_dur",       64'(dur), 64'd40);

        // trmt with clr_done in IDLE: frame starts and tx_done is 0
        run4(8'h55, 1'b1, 0, -1, bits, dur, first, trace);
        check("trmt_clr_first", 64'(first), 64'(3'b010));
        check("trmt_clr_bits",  64'(bits),  64'(10'b1010101010));

        // clr_done in the completion cycle loses; alone a cycle later it clears
        run4(8'hA5, 1'b0, 2, 39, bits, dur, first, trace);
        check("clr_at_done_dur", 64'(dur), 64'd40);
        check("clr_at_done",     {63'd0, bus4.tx_done}, 64'd1);
        bus4.clr_done = 1'b1;
        tick();
        bus4.clr_done = 1'b0;
        check("clr_after_done",  {63'd0, bus4.tx_done}, 64'd0);

        // trmt during bit 4 is ignored
        run4(8'hA5, 1'b0, 1, 16, bits, dur, first, trace);
        check("ignore_bits", 64'(bits), 64'(10'b1101001010));
        check("ignore_dur",  64'(dur),  64'd40);
        repeat (8) tick();
        check("ignore_busy", {63'd0, bus4.tx_busy}, 64'd0);
        check("ignore_tx",   {63'd0, tx4}, 64'd1);

        // Reset during bit 3 aborts the frame immediately
        bus4.tx_data = 8'hA5;
        bus4.trmt    = 1'b1;
        tick();
        bus4.trmt = 1'b0;
        repeat (13) tick();
        check("pre_rst_busy", {63'd0, bus4.tx_busy}, 64'd1);
        rst_b = 1'b1;
        #1;
        check("rst_mid_tx",   {63'd0, tx4}, 64'd1);
        check("rst_mid_busy", {63'd0, bus4.tx_busy}, 64'd0);
        check("rst_mid_done", {63'd0, bus4.tx_done}, 64'd0);
        tick();
        rst_b = 1'b0;
        repeat (45) tick();
        check("rst_no_done", {63'd0, bus4.tx_done}, 64'd0);
        check("rst_idle_tx", {63'd0, tx4}, 64'd1);
        run4(8'h81, 1'b0, 0, -1, bits, dur, first, trace);
        check("post_rst_first", 64'(first), 64'(3'b010));
        check("post_rst_bits",  64'(bits),  64'(10'b1100000010));
        check("post_rst_dur",   64'(dur),   64'd40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
